// File: rtl/mips_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_program_loader
// Purpose  : Framed byte-stream loader for MIPS instruction/data memories;
//            holds the core in reset until a run command arrives.
// Revision : 1.0 - initial release
// ============================================================================
module mips_program_loader #(
  parameter logic [7:0] CMD_INSTR = 8'hA5,
  parameter logic [7:0] CMD_DATA  = 8'h5A,
  parameter logic [7:0] CMD_RUN   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        instr_write_enable,
  output logic [7:0]  instr_write_addr,
  output logic [31:0] instr_write_data,
  output logic        data_init_write_enable,
  output logic [7:0]  data_init_addr,
  output logic [31:0] data_init_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_is_data;
  logic [8:0]  r_remaining;
  logic [7:0]  r_addr;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;

  logic w_accept;
  logic w_hdr_state;
  logic w_hdr_load;
  logic w_hdr_run;
  logic w_hdr_bad;
  logic w_word_done;
  logic w_last_word;

  assign w_accept    = in_valid && in_ready;
  assign w_hdr_state = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_hdr_load  = (in_data == CMD_INSTR) || (in_data == CMD_DATA);
  assign w_hdr_run   = (in_data == CMD_RUN);
  assign w_hdr_bad   = w_hdr_state && w_accept && !w_hdr_load && !w_hdr_run;
  assign w_word_done = (r_state == S_DATA) && w_accept && (r_byte_idx == 2'd3);
  assign w_last_word = (r_remaining == 9'd1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept) begin
          if (w_hdr_load) begin
            w_next_state = S_COUNT;
          end else if (w_hdr_run) begin
            w_next_state = S_RUN;
          end
        end
      end
      S_COUNT: if (w_accept) w_next_state = S_ADDR;
      S_ADDR:  if (w_accept) w_next_state = S_DATA;
      S_DATA:  if (w_word_done) w_next_state = S_WRITE;
      S_WRITE: w_next_state = w_last_word ? S_IDLE : S_DATA;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs; the core only runs while parked in RUN
  always_comb begin
    in_ready               = (r_state != S_WRITE);
    busy                   = !w_hdr_state;
    cpu_reset              = (r_state != S_RUN);
    instr_write_enable     = (r_state == S_WRITE) && !r_is_data;
    data_init_write_enable = (r_state == S_WRITE) && r_is_data;
  end

  // Frame context: target, word count, address, byte assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_data   <= 1'b0;
      r_remaining <= 9'd0;
      r_addr      <= 8'h00;
      r_byte_idx  <= 2'd0;
      r_shift     <= 24'h0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_accept && w_hdr_load) begin
            r_is_data <= (in_data == CMD_DATA);
          end
        end
        S_COUNT: begin
          // A count byte of zero encodes a full 256-word section
          if (w_accept) begin
            r_remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr     <= in_data;
            r_byte_idx <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], in_data};
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_remaining <= r_remaining - 9'd1;
          r_addr      <= r_addr + 8'd1;
        end
        default: begin
          r_byte_idx <= 2'd0;
        end
      endcase
    end
  end

  // Write buses are captured with the final byte so they are valid in WRITE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_write_addr <= 8'h00;
      instr_write_data <= 32'h0;
      data_init_addr   <= 8'h00;
      data_init_data   <= 32'h0;
    end else if (w_word_done) begin
      if (r_is_data) begin
        data_init_addr <= r_addr;
        data_init_data <= {r_shift, in_data};
      end else begin
        instr_write_addr <= r_addr;
        instr_write_data <= {r_shift, in_data};
      end
    end
  end

  // Sticky error and saturating word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error        <= 1'b0;
      words_loaded <= 16'h0000;
    end else begin
      if (w_hdr_bad) begin
        error <= 1'b1;
      end
      if ((r_state == S_WRITE) && (words_loaded != 16'hFFFF)) begin
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_program_loader
// Purpose  : Directed self-checking bench for mips_program_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        instr_write_enable;
  logic [7:0]  instr_write_addr;
  logic [31:0] instr_write_data;
  logic        data_init_write_enable;
  logic [7:0]  data_init_addr;
  logic [31:0] data_init_data;
  logic        cpu_reset;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ia [0:1023];
  logic [31:0] id [0:1023];
  logic [7:0]  da [0:1023];
  logic [31:0] dd [0:1023];
  int ni = 0;
  int nd = 0;

  mips_program_loader dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_data                (in_data),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .instr_write_enable     (instr_write_enable),
    .instr_write_addr       (instr_write_addr),
    .instr_write_data       (instr_write_data),
    .data_init_write_enable (data_init_write_enable),
    .data_init_addr         (data_init_addr),
    .data_init_data         (data_init_data),
    .cpu_reset              (cpu_reset),
    .busy                   (busy),
    .error                  (error),
    .words_loaded           (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe logger: every write is recorded, and in_ready must track the strobe
  always @(negedge clk) begin
    if (instr_write_enable || data_init_write_enable) begin
      check_eq("ready_low_on_strobe", 32'(in_ready), 32'd0);
      check_eq("single_enable", 32'(instr_write_enable & data_init_write_enable), 32'd0);
      if (instr_write_enable && ni < 1024) begin
        ia[ni] = instr_write_addr;
        id[ni] = instr_write_data;
        ni++;
      end
      if (data_init_write_enable && nd < 1024) begin
        da[nd] = data_init_addr;
        dd[nd] = data_init_data;
        nd++;
      end
    end else begin
      check_eq("ready_high_idle", 32'(in_ready), 32'd1);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[31:24], gap);
    send(w[23:16], gap);
    send(w[15:8],  gap);
    send(w[7:0],   gap);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_we"}, 32'({instr_write_enable, data_init_write_enable}), 32'd0);
    check_eq({tag, "_iaddr"}, 32'(instr_write_addr), 32'd0);
    check_eq({tag, "_idata"}, instr_write_data, 32'd0);
    check_eq({tag, "_daddr"}, 32'(data_init_addr), 32'd0);
    check_eq({tag, "_ddata"}, data_init_data, 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_words"}, 32'(words_loaded), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bi;
    int bd;
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    // Single instruction word; strobe visible in the cycle after the last byte
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    send_word(32'h2002000A, 0);
    check_eq("t1_we", 32'(instr_write_enable), 32'd1);
    check_eq("t1_addr", 32'(instr_write_addr), 32'h00);
    check_eq("t1_data", instr_write_data, 32'h2002000A);
    check_eq("t1_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("t1_cnt", 32'(ni), 32'd1);
    check_eq("t1_words", 32'(words_loaded), 32'd1);
    check_eq("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_hold_data", instr_write_data, 32'h2002000A);

    // Two data words
    send(8'h5A, 0); send(8'h02, 0); send(8'h10, 0);
    send_word(32'h00000005, 0);
    send_word(32'h00000007, 0);
    repeat (2) @(negedge clk);
    check_eq("t2_dcnt", 32'(nd), 32'd2);
    check_eq("t2_icnt", 32'(ni), 32'd1);
    check_eq("t2_a0", 32'(da[0]), 32'h10);
    check_eq("t2_d0", dd[0], 32'h5);
    check_eq("t2_a1", 32'(da[1]), 32'h11);
    check_eq("t2_d1", dd[1], 32'h7);
    check_eq("t2_words", 32'(words_loaded), 32'd3);

    // Address wrap FF -> 00
    send(8'hA5, 0); send(8'h02, 0); send(8'hFF, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    repeat (2) @(negedge clk);
    check_eq("t3_icnt", 32'(ni), 32'd3);
    check_eq("t3_a0", 32'(ia[1]), 32'hFF);
    check_eq("t3_d0", id[1], 32'h11111111);
    check_eq("t3_a1", 32'(ia[2]), 32'h00);
    check_eq("t3_d1", id[2], 32'h22222222);
    check_eq("t3_words", 32'(words_loaded), 32'd5);

    // Unknown header, then run, then a reload from RUN
    send(8'h3C, 0);
    check_eq("t4_error", 32'(error), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'hFF, 0);
    check_eq("t4_run", 32'(cpu_reset), 32'd0);
    check_eq("t4_error_sticky", 32'(error), 32'd1);
    send(8'h77, 0);
    check_eq("t4_run_bad_hdr", 32'(cpu_reset), 32'd0);
    send(8'hA5, 0);
    check_eq("t4_reassert", 32'(cpu_reset), 32'd1);
    send(8'h01, 0); send(8'h20, 0);
    send_word(32'hDEADBEEF, 0);
    repeat (2) @(negedge clk);
    check_eq("t4_icnt", 32'(ni), 32'd4);
    check_eq("t4_a", 32'(ia[3]), 32'h20);
    check_eq("t4_d", id[3], 32'hDEADBEEF);
    check_eq("t4_words", 32'(words_loaded), 32'd6);

    // Reset mid-payload discards the partial word
    bi = ni;
    bd = nd;
    send(8'hA5, 0); send(8'h01, 0); send(8'h05, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("t5");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_no_strobe", 32'(ni), 32'(bi));
    send(8'h5A, 0); send(8'h01, 0); send(8'h03, 0);
    send_word(32'hCAFEF00D, 0);
    repeat (2) @(negedge clk);
    check_eq("t5_dcnt", 32'(nd), 32'(bd + 1));
    check_eq("t5_a", 32'(da[bd]), 32'h03);
    check_eq("t5_d", dd[bd], 32'hCAFEF00D);
    check_eq("t5_words", 32'(words_loaded), 32'd1);

    // in_valid toggling every other cycle
    bi = ni;
    send(8'hA5, 1); send(8'h03, 1); send(8'h40, 1);
    send_word(32'h01020304, 1);
    send_word(32'hA0B0C0D0, 1);
    send_word(32'h0000FFFF, 1);
    repeat (2) @(negedge clk);
    check_eq("t6_icnt", 32'(ni), 32'(bi + 3));
    check_eq("t6_a0", 32'(ia[bi]), 32'h40);
    check_eq("t6_d0", id[bi], 32'h01020304);
    check_eq("t6_a1", 32'(ia[bi+1]), 32'h41);
    check_eq("t6_d1", id[bi+1], 32'hA0B0C0D0);
    check_eq("t6_a2", 32'(ia[bi+2]), 32'h42);
    check_eq("t6_d2", id[bi+2], 32'h0000FFFF);
    check_eq("t6_words", 32'(words_loaded), 32'd4);

    // N=0 -> 256 words starting at 80, wrapping through FF -> 00
    bd = nd;
    send(8'h5A, 0); send(8'h00, 0); send(8'h80, 0);
    for (int k = 0; k < 256; k++) begin
      send_word(32'h10000000 + 32'(k), 0);
    end
    repeat (2) @(negedge clk);
    check_eq("t7_dcnt", 32'(nd), 32'(bd + 256));
    for (int k = 0; k < 256; k++) begin
      check_eq("t7_addr", 32'(da[bd+k]), 32'((8'h80 + k) % 256));
      check_eq("t7_data", dd[bd+k], 32'h10000000 + 32'(k));
    end
    check_eq("t7_words", 32'(words_loaded), 32'd260);
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
